// File: rtl/fetch_control_pkg.sv
// fetch_control_pkg: shared constants and types for the instruction-fetch control block.
//   RESET_PC  - PC value loaded on reset
//   NOP_INSTR - encoding written into IF/ID on a bubble (sll $0,$0,0)
//   fetchState_e - fetch FSM states (IDLE, FETCH, HOLD, DROP)
//   alignPc   - clears the two low address bits of a redirect target
package fetch_control_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC  = 32'h0000_0000;
  localparam word_t NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrop
  } fetchState_e;

  function automatic word_t alignPc(input word_t addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_control_if.sv
// fetch_control_if: bundles the hazard-unit controls, the instruction-memory ready/valid bus,
// the IF/ID pipeline register outputs and the optional hazard statistics.
//   master modport - the fetch_control side (drives imemReq/imemAddr and IF/ID)
//   slave modport  - the environment side (hazard unit, instruction memory, decode)
interface fetch_control_if;
  import fetch_control_pkg::*;

  // Hazard unit
  logic        pcStop;
  logic        ifIdWrite;
  logic        ifIdFlush;
  logic        branchTaken;
  word_t       branchTarget;
  // Instruction memory
  logic        imemReady;
  word_t       imemData;
  logic        imemReq;
  word_t       imemAddr;
  // IF/ID register
  word_t       ifIdInstr;
  word_t       ifIdPc4;
  logic        ifIdValid;
  // Statistics
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  modport master (
    input  pcStop, ifIdWrite, ifIdFlush, branchTaken, branchTarget, imemReady, imemData,
    output imemReq, imemAddr, ifIdInstr, ifIdPc4, ifIdValid, stallCount, flushCount
  );

  modport slave (
    output pcStop, ifIdWrite, ifIdFlush, branchTaken, branchTarget, imemReady, imemData,
    input  imemReq, imemAddr, ifIdInstr, ifIdPc4, ifIdValid, stallCount, flushCount
  );

endinterface

// File: rtl/fetch_control_hazard_stats.sv
// hazard_stats: two saturating 16-bit event counters for stall cycles and inserted bubbles.
// Only built when HAZARD_STATS_EN is defined, so a default build carries no counter flops.
//   clock, reset      - system clock, asynchronous active-high reset
//   stallInc          - count one stall cycle
//   flushInc          - count one bubble caused by a branch or flush
//   stallCount/flushCount - counter values, saturating at 16'hFFFF
`ifdef HAZARD_STATS_EN
module hazard_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        stallInc,
  input  logic        flushInc,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stallInc && (stallCount != 16'hFFFF)) stallCount <= stallCount + 16'd1;
      if (flushInc && (flushCount != 16'hFFFF)) flushCount <= flushCount + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/fetch_control.sv
// fetch_control: owns the PC, issues ready/valid fetch requests to instruction memory and
// writes the IF/ID register, honouring stall (hold) and flush/branch (bubble) requests.
//   clock, reset - system clock, asynchronous active-high reset
//   bus          - fetch_control_if.master: hazard controls, imem bus, IF/ID outputs, stats
// Optional feature: define HAZARD_STATS_EN to build the stall/flush counters; otherwise
// stallCount and flushCount are driven 0.
module fetch_control
  import fetch_control_pkg::*;
(
  input logic             clock,
  input logic             reset,
  fetch_control_if.master bus
);

  fetchState_e stateQ;
  word_t       pcQ;
  word_t       addrQ;
  logic        reqQ;
  word_t       instrQ;
  word_t       pc4Q;
  logic        validQ;
  word_t       bufInstrQ;
  word_t       bufPc4Q;

  logic  hold;
  word_t pcPlus4;
  word_t target;

  assign hold    = bus.pcStop | ~bus.ifIdWrite;
  assign pcPlus4 = pcQ + 32'd4;
  assign target  = alignPc(bus.branchTarget);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ    <= StIdle;
      pcQ       <= RESET_PC;
      addrQ     <= RESET_PC;
      reqQ      <= 1'b0;
      instrQ    <= NOP_INSTR;
      pc4Q      <= '0;
      validQ    <= 1'b0;
      bufInstrQ <= NOP_INSTR;
      bufPc4Q   <= '0;
    end else if (hold) begin
      // PC and IF/ID frozen; only the memory handshake is allowed to progress.
      unique case (stateQ)
        StIdle: begin
          stateQ <= StFetch;
          reqQ   <= 1'b1;
          addrQ  <= pcQ;
        end
        StFetch: begin
          if (bus.imemReady) begin
            bufInstrQ <= bus.imemData;
            bufPc4Q   <= pcPlus4;
            stateQ    <= StHold;
            reqQ      <= 1'b0;
          end
        end
        StHold: begin
        end
        StDrop: begin
          if (bus.imemReady) begin
            stateQ <= StFetch;
            addrQ  <= pcQ;
          end
        end
      endcase
    end else if (bus.branchTaken) begin
      pcQ    <= target;
      instrQ <= NOP_INSTR;
      pc4Q   <= '0;
      validQ <= 1'b0;
      reqQ   <= 1'b1;
      // An outstanding request must still be retired at its original address.
      if (reqQ && !bus.imemReady) begin
        stateQ <= StDrop;
      end else begin
        stateQ <= StFetch;
        addrQ  <= target;
      end
    end else begin
      // Default IF/ID update is a bubble; a delivered instruction overrides it below.
      instrQ <= NOP_INSTR;
      pc4Q   <= '0;
      validQ <= 1'b0;
      unique case (stateQ)
        StIdle: begin
          stateQ <= StFetch;
          reqQ   <= 1'b1;
          addrQ  <= pcQ;
        end
        StFetch: begin
          if (bus.imemReady) begin
            pcQ   <= pcPlus4;
            addrQ <= pcPlus4;
            if (!bus.ifIdFlush) begin
              instrQ <= bus.imemData;
              pc4Q   <= pcPlus4;
              validQ <= 1'b1;
            end
          end
        end
        StHold: begin
          pcQ    <= pcPlus4;
          addrQ  <= pcPlus4;
          reqQ   <= 1'b1;
          stateQ <= StFetch;
          if (!bus.ifIdFlush) begin
            instrQ <= bufInstrQ;
            pc4Q   <= bufPc4Q;
            validQ <= 1'b1;
          end
        end
        StDrop: begin
          if (bus.imemReady) begin
            stateQ <= StFetch;
            addrQ  <= pcQ;
          end
        end
      endcase
    end
  end

  assign bus.imemReq   = reqQ;
  assign bus.imemAddr  = addrQ;
  assign bus.ifIdInstr = instrQ;
  assign bus.ifIdPc4   = pc4Q;
  assign bus.ifIdValid = validQ;

`ifdef HAZARD_STATS_EN
  logic flushEvent;
  assign flushEvent = ~hold & (bus.branchTaken | bus.ifIdFlush);

  hazard_stats uStats (
    .clock      (clock),
    .reset      (reset),
    .stallInc   (hold),
    .flushInc   (flushEvent),
    .stallCount (bus.stallCount),
    .flushCount (bus.flushCount)
  );
`else
  assign bus.stallCount = '0;
  assign bus.flushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: directed, table-driven bench for fetch_control. Instruction memory is
// modelled as imem[a] = a, so every delivered instruction equals its own fetch address.
module tb_fetch_control;
  import fetch_control_pkg::*;

  logic clock;
  logic reset;

  fetch_control_if ifc ();

  fetch_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ifc.imemData = ifc.imemAddr;

`ifdef HAZARD_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  typedef struct {
    logic        stop;
    logic        wr;
    logic        fl;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    int unsigned stl;
    int unsigned fls;
  } vec_t;

  localparam int NumVec = 27;
  vec_t vecs [NumVec];

  int total;
  int passed;

  function automatic vec_t mk(input logic stop, input logic wr, input logic fl, input logic br,
                              input logic [31:0] tgt, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid,
                              input int unsigned stl, input int unsigned fls);
    vec_t v;
    v.stop = stop; v.wr = wr; v.fl = fl; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.req = req; v.addr = addr; v.instr = instr; v.pc4 = pc4; v.valid = valid;
    v.stl = stl; v.fls = fls;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkAll(input string tag, input logic req, input logic [31:0] addr,
                          input logic [31:0] instr, input logic [31:0] pc4, input logic valid,
                          input int unsigned stl, input int unsigned fls);
    check({tag, ".imemReq"}, {31'd0, ifc.imemReq}, {31'd0, req});
    check({tag, ".imemAddr"}, ifc.imemAddr, addr);
    check({tag, ".ifIdInstr"}, ifc.ifIdInstr, instr);
    check({tag, ".ifIdPc4"}, ifc.ifIdPc4, pc4);
    check({tag, ".ifIdValid"}, {31'd0, ifc.ifIdValid}, {31'd0, valid});
    check({tag, ".stallCount"}, {16'd0, ifc.stallCount}, StatsOn ? stl : 32'd0);
    check({tag, ".flushCount"}, {16'd0, ifc.flushCount}, StatsOn ? fls : 32'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;

    //             stop wr fl br tgt           rdy | req addr          instr         pc4           v stl fls
    vecs[0]  = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h4,        32'h0,        32'h4,        1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h8,        32'h4,        32'h8,        1, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'hC,        32'h8,        32'hC,        1, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h10,       32'hC,        32'h10,       1, 0, 0);
    // Stall while the fetch at 0x10 completes: buffered, IF/ID and PC frozen.
    vecs[5]  = mk(1, 1, 0, 0, 32'h0,         1,   0, 32'h10,       32'hC,        32'h10,       1, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 32'h0,         1,   0, 32'h10,       32'hC,        32'h10,       1, 2, 0);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,         1,   0, 32'h10,       32'hC,        32'h10,       1, 3, 0);
    vecs[8]  = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h14,       32'h10,       32'h14,       1, 3, 0);
    vecs[9]  = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h18,       32'h14,       32'h18,       1, 3, 0);
    // Taken branch with zero-wait memory: one bubble, then the target.
    vecs[10] = mk(0, 1, 0, 1, 32'h100,       1,   1, 32'h100,      32'h0,        32'h0,        0, 3, 1);
    vecs[11] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h104,      32'h100,      32'h104,      1, 3, 1);
    // Flush: bubble, PC still advances past the discarded instruction.
    vecs[12] = mk(0, 1, 1, 0, 32'h0,         1,   1, 32'h108,      32'h0,        32'h0,        0, 3, 2);
    vecs[13] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h10C,      32'h108,      32'h10C,      1, 3, 2);
    // Wait state: bubble, address stable.
    vecs[14] = mk(0, 1, 0, 0, 32'h0,         0,   1, 32'h10C,      32'h0,        32'h0,        0, 3, 2);
    vecs[15] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h110,      32'h10C,      32'h110,      1, 3, 2);
    // Branch while a request is pending: DROP holds the old address until the response.
    vecs[16] = mk(0, 1, 0, 1, 32'h80,        0,   1, 32'h110,      32'h0,        32'h0,        0, 3, 3);
    vecs[17] = mk(0, 1, 0, 0, 32'h0,         0,   1, 32'h110,      32'h0,        32'h0,        0, 3, 3);
    vecs[18] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h80,       32'h0,        32'h0,        0, 3, 3);
    vecs[19] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h84,       32'h80,       32'h84,       1, 3, 3);
    // Branch under pcStop is ignored; reasserted without stall it redirects (target aligned).
    vecs[20] = mk(1, 1, 0, 1, 32'h200,       1,   0, 32'h84,       32'h80,       32'h84,       1, 4, 3);
    vecs[21] = mk(0, 1, 0, 1, 32'h203,       1,   1, 32'h200,      32'h0,        32'h0,        0, 4, 4);
    vecs[22] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h204,      32'h200,      32'h204,      1, 4, 4);
    // PC wraps modulo 2^32.
    vecs[23] = mk(0, 1, 0, 1, 32'hFFFF_FFFE, 1,   1, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 4, 5);
    vecs[24] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h0,        32'hFFFF_FFFC, 32'h0,       1, 4, 5);
    vecs[25] = mk(0, 1, 0, 0, 32'h0,         1,   1, 32'h4,        32'h0,        32'h4,        1, 4, 5);
    // Enter HOLD with instruction 0x4 buffered, ahead of the asynchronous reset below.
    vecs[26] = mk(1, 1, 0, 0, 32'h0,         1,   0, 32'h4,        32'h0,        32'h4,        1, 5, 5);

    reset            = 1'b1;
    ifc.pcStop       = 1'b0;
    ifc.ifIdWrite    = 1'b1;
    ifc.ifIdFlush    = 1'b0;
    ifc.branchTaken  = 1'b0;
    ifc.branchTarget = '0;
    ifc.imemReady    = 1'b1;

    #3;
    checkAll("reset", 1'b0, RESET_PC, NOP_INSTR, 32'h0, 1'b0, 0, 0);

    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      if (i != 0) @(negedge clock);
      ifc.pcStop       = vecs[i].stop;
      ifc.ifIdWrite    = vecs[i].wr;
      ifc.ifIdFlush    = vecs[i].fl;
      ifc.branchTaken  = vecs[i].br;
      ifc.branchTarget = vecs[i].tgt;
      ifc.imemReady    = vecs[i].rdy;
      @(posedge clock);
      #1;
      checkAll($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].instr, vecs[i].pc4,
               vecs[i].valid, vecs[i].stl, vecs[i].fls);
    end

    // Asynchronous reset during HOLD: immediate return to reset values.
    #2;
    reset = 1'b1;
    #1;
    checkAll("asyncReset", 1'b0, RESET_PC, NOP_INSTR, 32'h0, 1'b0, 0, 0);

    ifc.pcStop      = 1'b0;
    ifc.branchTaken = 1'b0;
    ifc.imemReady   = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkAll("postReset1", 1'b1, 32'h0, NOP_INSTR, 32'h0, 1'b0, 0, 0);
    @(posedge clock);
    #1;
    // The buffered instruction (0x4, pc4 0x8) must not surface; fetch restarts at RESET_PC.
    checkAll("postReset2", 1'b1, 32'h4, 32'h0, 32'h4, 1'b1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
